// File: rtl/hbridge_output_stage.sv
// H-bridge pin driver: coasts for a fixed dead time before any direction change and
// drives period-synchronous PWM enables; every output comes straight from a flop.
module hbridge_output_stage #(
  parameter int DEADTIME_TICKS = 5000000,
  parameter int PWM_PRESCALE   = 1563,
  parameter int CNT_W          = 28
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] requestedINs,
  input  logic [5:0] speedDuty,
  output logic [3:0] H_BridgeINs,
  output logic       ENA,
  output logic       ENB,
  output logic [3:0] appliedINs,
  output logic       isCoasting
);

  localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME_TICKS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PWM_PRESCALE - 1);

  localparam logic [3:0] P_COAST = 4'b0000;
  localparam logic [3:0] P_BRAKE = 4'b1111;
  localparam logic [3:0] P_FWD   = 4'b0110;
  localparam logic [3:0] P_REV   = 4'b1001;
  localparam logic [3:0] P_RIGHT = 4'b0101;
  localparam logic [3:0] P_LEFT  = 4'b1010;

  typedef enum logic {S_RUN, S_COAST} state_t;

  state_t           r_state;
  logic [3:0]       r_applied;
  logic [3:0]       r_target;
  logic [CNT_W-1:0] r_dead_cnt;
  logic             r_coasting;
  logic             r_en;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [5:0]       r_step;
  logic [5:0]       r_duty;

  logic       w_req_motion;
  logic       w_req_stop;
  logic       w_app_stop;
  logic       w_tick;
  logic       w_wrap;
  logic [5:0] w_step_nxt;
  logic [5:0] w_duty_nxt;
  logic       w_pwm_on;
  logic [3:0] w_coast_dst;

  assign w_req_motion = (requestedINs == P_FWD) || (requestedINs == P_REV) ||
                        (requestedINs == P_RIGHT) || (requestedINs == P_LEFT);
  assign w_req_stop   = (requestedINs == P_COAST) || (requestedINs == P_BRAKE);
  assign w_app_stop   = (r_applied == P_COAST) || (r_applied == P_BRAKE);

  assign w_tick      = (r_pre_cnt == PRE_LAST);
  assign w_wrap      = w_tick && (r_step == 6'd63);
  assign w_step_nxt  = w_tick ? r_step + 6'd1 : r_step;
  assign w_duty_nxt  = w_wrap ? speedDuty : r_duty;
  assign w_pwm_on    = (w_step_nxt < w_duty_nxt);
  assign w_coast_dst = w_req_motion ? requestedINs : r_target;

  // Enable is evaluated against the pattern being applied on the same edge,
  // so it can never lag the pins into a coast or brake.
  function automatic logic pwm_en(input logic [3:0] pat, input logic on);
    return (pat == P_BRAKE) || ((pat != P_COAST) && on);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt <= '0;
      r_step    <= '0;
      r_duty    <= '0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
      r_step    <= w_step_nxt;
      r_duty    <= w_duty_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_RUN;
      r_applied  <= P_COAST;
      r_target   <= P_COAST;
      r_dead_cnt <= '0;
      r_coasting <= 1'b0;
      r_en       <= 1'b0;
    end else begin
      r_en <= pwm_en(r_applied, w_pwm_on);
      case (r_state)
        S_RUN: begin
          if ((requestedINs != r_applied) && (w_req_motion || w_req_stop)) begin
            if (w_req_stop || w_app_stop) begin
              r_applied <= requestedINs;
              r_en      <= pwm_en(requestedINs, w_pwm_on);
            end else begin
              r_applied  <= P_COAST;
              r_en       <= 1'b0;
              r_target   <= requestedINs;
              r_dead_cnt <= '0;
              r_coasting <= 1'b1;
              r_state    <= S_COAST;
            end
          end
        end
        S_COAST: begin
          r_dead_cnt <= r_dead_cnt + CNT_W'(1);
          // Brake beats terminal count; a motion request on the last cycle is taken directly.
          if (requestedINs == P_BRAKE) begin
            r_applied  <= P_BRAKE;
            r_en       <= 1'b1;
            r_coasting <= 1'b0;
            r_state    <= S_RUN;
          end else if (requestedINs == P_COAST) begin
            r_coasting <= 1'b0;
            r_state    <= S_RUN;
          end else if (r_dead_cnt == DEAD_LAST) begin
            r_applied  <= w_coast_dst;
            r_en       <= pwm_en(w_coast_dst, w_pwm_on);
            r_coasting <= 1'b0;
            r_state    <= S_RUN;
          end else if (w_req_motion) begin
            r_target <= requestedINs;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign H_BridgeINs = r_applied;
  assign appliedINs  = r_applied;
  assign isCoasting  = r_coasting;
  assign ENA         = r_en;
  assign ENB         = r_en;

endmodule

// File: tb/tb_hbridge_output_stage.sv
// Randomized scoreboard bench for hbridge_output_stage with a timestamp-based reference model.
module tb_hbridge_output_stage;

  localparam int DT = 10;
  localparam int P  = 2;

  logic       clock;
  logic       reset_n;
  logic [3:0] requestedINs;
  logic [5:0] speedDuty;
  logic [3:0] H_BridgeINs;
  logic       ENA;
  logic       ENB;
  logic [3:0] appliedINs;
  logic       isCoasting;

  int total = 0;
  int bad   = 0;

  logic [5:0] exp_q[$];

  hbridge_output_stage #(
    .DEADTIME_TICKS(DT),
    .PWM_PRESCALE  (P),
    .CNT_W         (28)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .requestedINs(requestedINs),
    .speedDuty   (speedDuty),
    .H_BridgeINs (H_BridgeINs),
    .ENA         (ENA),
    .ENB         (ENB),
    .appliedINs  (appliedINs),
    .isCoasting  (isCoasting)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_motion(input logic [3:0] p);
    return (p == 4'b0110) || (p == 4'b1001) || (p == 4'b0101) || (p == 4'b1010);
  endfunction

  function automatic bit is_stop(input logic [3:0] p);
    return (p == 4'b0000) || (p == 4'b1111);
  endfunction

  // Reference model: k counts clock edges since reset release; PWM position and
  // duty latching follow from k arithmetically, the coast from an end timestamp.
  logic [3:0] m_applied = 4'b0000;
  logic [3:0] m_target  = 4'b0000;
  bit         m_coast   = 1'b0;
  int         m_end     = 0;
  int         m_k       = 0;
  logic [5:0] m_duty    = 6'd0;
  logic [3:0] m_req;
  int         m_step;
  logic       m_en;

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      m_applied = 4'b0000;
      m_target  = 4'b0000;
      m_coast   = 1'b0;
      m_end     = 0;
      m_k       = 0;
      m_duty    = 6'd0;
      exp_q.delete();
    end else begin
      m_req = requestedINs;
      m_k++;
      if (m_coast) begin
        if (m_req == 4'b1111) begin
          m_applied = 4'b1111;
          m_coast   = 1'b0;
        end else if (m_req == 4'b0000) begin
          m_coast = 1'b0;
        end else if (m_k == m_end) begin
          m_applied = is_motion(m_req) ? m_req : m_target;
          m_coast   = 1'b0;
        end else if (is_motion(m_req)) begin
          m_target = m_req;
        end
      end else if ((m_req != m_applied) && (is_motion(m_req) || is_stop(m_req))) begin
        if (is_stop(m_req) || is_stop(m_applied)) begin
          m_applied = m_req;
        end else begin
          m_applied = 4'b0000;
          m_target  = m_req;
          m_coast   = 1'b1;
          m_end     = m_k + DT;
        end
      end
      if (m_k % (64 * P) == 0) m_duty = speedDuty;
      m_step = (m_k / P) % 64;
      if (m_applied == 4'b1111)      m_en = 1'b1;
      else if (m_applied == 4'b0000) m_en = 1'b0;
      else                           m_en = (m_step < int'(m_duty));
      exp_q.push_back({m_applied, m_coast, m_en});
    end
  end

  logic [5:0] mon_e;

  initial forever begin
    @(negedge clock);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("H_BridgeINs", 8'(H_BridgeINs), 8'(mon_e[5:2]));
      check("appliedINs",  8'(appliedINs),  8'(mon_e[5:2]));
      check("isCoasting",  8'(isCoasting),  8'(mon_e[1]));
      check("ENA",         8'(ENA),         8'(mon_e[0]));
      check("ENB",         8'(ENB),         8'(mon_e[0]));
    end
  end

  task automatic drive(input logic [3:0] req, input logic [5:0] spd, input int n);
    requestedINs = req;
    speedDuty    = spd;
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pins"},  8'(H_BridgeINs), 8'h0);
    check({tag, "_appl"},  8'(appliedINs),  8'h0);
    check({tag, "_coast"}, 8'(isCoasting),  8'h0);
    check({tag, "_ena"},   8'(ENA),         8'h0);
    check({tag, "_enb"},   8'(ENB),         8'h0);
  endtask

  // Called at posedge+2: drops reset between edges and checks the async clear.
  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  logic [3:0] pats [8] = '{4'b0110, 4'b1001, 4'b0101, 4'b1010,
                           4'b0000, 4'b1111, 4'b0011, 4'b1100};

  initial begin
    int idx;
    logic [5:0] spd;
    reset_n      = 1'b0;
    requestedINs = 4'b0000;
    speedDuty    = 6'd0;
    repeat (3) @(posedge clock);
    #2;
    check_reset_outputs("por");
    reset_n = 1'b1;

    drive(4'b0110, 6'd32, 300);
    drive(4'b1001, 6'd32, 15);
    drive(4'b0110, 6'd32, 15);
    drive(4'b1001, 6'd32, 4);
    drive(4'b1111, 6'd32, 20);
    drive(4'b0110, 6'd32, 3);
    drive(4'b0101, 6'd32, 3);
    drive(4'b1010, 6'd32, 14);
    drive(4'b1010, 6'd10, 190);
    drive(4'b1010, 6'd50, 260);
    drive(4'b0011, 6'd50, 10);
    drive(4'b1010, 6'd0, 140);
    drive(4'b1010, 6'd63, 270);
    drive(4'b0110, 6'd63, 6);
    drive(4'b0000, 6'd63, 5);
    drive(4'b0110, 6'd20, 5);
    drive(4'b1001, 6'd20, 4);
    async_reset("midcoast");
    drive(4'b0110, 6'd40, 20);

    for (int i = 0; i < 400; i++) begin
      idx = $urandom_range(0, 11);
      if (idx > 7) idx = idx - 8;
      spd = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) spd = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'd63;
      if ($urandom_range(0, 59) == 0) async_reset("rand_rst");
      else drive(pats[idx], spd, $urandom_range(1, 14));
    end

    @(negedge clock);
    #1;
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
